// File: rtl/mitchell_mul_pipe_if.sv
// Streaming handshake bundle for mitchell_mul_pipe.
// Carries the operand side (in_valid/in_ready/a/b) and the product side (out_valid/out_ready/c).
// The slave modport is the multiplier's view and the master modport is the source/sink view.
interface mitchell_mul_pipe_if #(
  parameter int W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   c;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/mitchell_mul_pipe.sv
// Three-stage pipelined Mitchell logarithmic multiplier (unsigned, W x W -> 2W).
// Results are bit-identical to the combinational Mitchell model.
// All stages advance together when the output register is empty or being drained.
// Optional feature: define MITCHELL_STATS_EN to add the prod_cnt completed-product counter.
module mitchell_mul_pipe #(
  parameter int W     = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MITCHELL_STATS_EN
  output logic [CNT_W-1:0]  prod_cnt,
`endif
  mitchell_mul_pipe_if.slave bus
);

  localparam int KW = $clog2(W);
  localparam int EW = $clog2(2 * W);
  localparam int PW = 3 * W - 1;

  // Position of the most significant set bit; an input of zero yields 0 and is masked later.
  function automatic logic [KW-1:0] lead_one(input logic [W-1:0] x);
    logic [KW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) r = KW'(i);
    end
    return r;
  endfunction

  // Normalise so the leading one is just above bit W-2, then drop it: W-1 fraction bits.
  function automatic logic [W-2:0] frac(input logic [W-1:0] x, input logic [KW-1:0] k);
    logic [KW-1:0] sh;
    sh = KW'(W - 1) - k;
    return (W-1)'(x << sh);
  endfunction

  // Antilog: shift the mantissa by the exponent exactly, then drop the W-1 fraction bits.
  function automatic logic [2*W-1:0] scale(input logic [W-1:0] mant, input logic [EW-1:0] e);
    logic [PW-1:0] wide;
    wide = PW'(mant) << e;
    return (2*W)'(wide >> (W - 1));
  endfunction

  logic adv;

  logic            vld_p1_q, vld_p1_d;
  logic [W-1:0]    a_p1_q, a_p1_d, b_p1_q, b_p1_d;
  logic            zero_p1_q, zero_p1_d;
  logic [KW-1:0]   k1_p1_q, k1_p1_d, k2_p1_q, k2_p1_d;

  logic            vld_p2_q, vld_p2_d;
  logic [W-1:0]    mant_p2_q, mant_p2_d;
  logic [EW-1:0]   e_p2_q, e_p2_d;
  logic            zero_p2_q, zero_p2_d;

  logic            vld_p3_q, vld_p3_d;
  logic [2*W-1:0]  c_p3_q, c_p3_d;

  logic [W-1:0]    s_p2;

  assign adv          = !vld_p3_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld_p3_q;
  assign bus.c        = c_p3_q;

  // Next-state for all three stages; every stage holds when the output is stalled.
  always_comb begin
    vld_p1_d  = vld_p1_q;
    a_p1_d    = a_p1_q;
    b_p1_d    = b_p1_q;
    zero_p1_d = zero_p1_q;
    k1_p1_d   = k1_p1_q;
    k2_p1_d   = k2_p1_q;
    vld_p2_d  = vld_p2_q;
    mant_p2_d = mant_p2_q;
    e_p2_d    = e_p2_q;
    zero_p2_d = zero_p2_q;
    vld_p3_d  = vld_p3_q;
    c_p3_d    = c_p3_q;
    s_p2      = {1'b0, frac(a_p1_q, k1_p1_q)} + {1'b0, frac(b_p1_q, k2_p1_q)};
    if (adv) begin
      // S1: capture operands and their leading-one positions
      vld_p1_d  = bus.in_valid;
      a_p1_d    = bus.a;
      b_p1_d    = bus.b;
      zero_p1_d = (bus.a == '0) || (bus.b == '0);
      k1_p1_d   = lead_one(bus.a);
      k2_p1_d   = lead_one(bus.b);
      // S2: add fractions; a carry out of the fraction sum bumps the exponent and
      // the mantissa is then the sum itself, otherwise 1.fraction -- both are {1, s[W-2:0]}
      vld_p2_d  = vld_p1_q;
      mant_p2_d = {1'b1, s_p2[W-2:0]};
      e_p2_d    = EW'(k1_p1_q) + EW'(k2_p1_q) + EW'(s_p2[W-1]);
      zero_p2_d = zero_p1_q;
      // S3: barrel shift and truncate into the product register
      vld_p3_d  = vld_p2_q;
      c_p3_d    = zero_p2_q ? '0 : scale(mant_p2_q, e_p2_q);
    end
  end

  // Pipeline registers; reset empties every stage and clears the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      zero_p1_q <= 1'b0;
      k1_p1_q   <= '0;
      k2_p1_q   <= '0;
      vld_p2_q  <= 1'b0;
      mant_p2_q <= '0;
      e_p2_q    <= '0;
      zero_p2_q <= 1'b0;
      vld_p3_q  <= 1'b0;
      c_p3_q    <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      zero_p1_q <= zero_p1_d;
      k1_p1_q   <= k1_p1_d;
      k2_p1_q   <= k2_p1_d;
      vld_p2_q  <= vld_p2_d;
      mant_p2_q <= mant_p2_d;
      e_p2_q    <= e_p2_d;
      zero_p2_q <= zero_p2_d;
      vld_p3_q  <= vld_p3_d;
      c_p3_q    <= c_p3_d;
    end
  end

`ifdef MITCHELL_STATS_EN
  logic [CNT_W-1:0] prod_cnt_q, prod_cnt_d;

  // Count every product handed downstream; wraps naturally at 2^CNT_W.
  always_comb begin
    prod_cnt_d = prod_cnt_q;
    if (vld_p3_q && bus.out_ready) prod_cnt_d = prod_cnt_q + 1'b1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_cnt_q <= '0;
    else        prod_cnt_q <= prod_cnt_d;
  end

  assign prod_cnt = prod_cnt_q;
`endif

endmodule

// File: tb/tb_mitchell_mul_pipe.sv
// Self-checking bench for mitchell_mul_pipe (W=16): directed corner cases, stall,
// reset with products in flight, and a randomized stream against a reference model.
module tb_mitchell_mul_pipe;
  localparam int W     = 16;
  localparam int CNT_W = 32;
  localparam int NSTREAM = 1000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mitchell_mul_pipe_if #(.W(W)) bus ();

`ifdef MITCHELL_STATS_EN
  logic [CNT_W-1:0] prod_cnt;
`endif

  mitchell_mul_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef MITCHELL_STATS_EN
    .prod_cnt (prod_cnt),
`endif
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  // Mitchell approximation with plain integer arithmetic:
  // log2(x) ~= k + f, sum the logs, antilog as (1+f)*2^k, then take floor.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ka, kb, fa, fb, s, mant, e, half, av, bv;
    if (a == 0 || b == 0) return '0;
    av = longint'(a);
    bv = longint'(b);
    ka = 0;
    kb = 0;
    for (int i = 0; i < W; i++) begin
      if (av >= (64'd1 << i)) ka = i;
      if (bv >= (64'd1 << i)) kb = i;
    end
    half = 64'd1 << (W - 1);
    fa = (av * (64'd1 << (W - 1 - ka))) % half;
    fb = (bv * (64'd1 << (W - 1 - kb))) % half;
    s  = fa + fb;
    if (s < half) begin
      mant = half + s;
      e    = ka + kb;
    end else begin
      mant = s;
      e    = ka + kb + 1;
    end
    return (2*W)'((mant * (64'd1 << e)) / half);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    int r;
    r = int'($urandom % 8);
    case (r)
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << ($urandom % W);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.c !== '0) begin
      failures++;
      $display("FAIL reset_c got=%h want=0", bus.c);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
`ifdef MITCHELL_STATS_EN
    checks++;
    if (prod_cnt !== '0) begin
      failures++;
      $display("FAIL reset_prod_cnt got=%0d want=0", prod_cnt);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single pair with an idle pipeline: product must appear exactly 3 cycles after acceptance.
  task automatic test_latency(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] exp_c, input string name);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready got=%b want=1", name, bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_valid got=%b want=0", name, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_out_valid got=%b want=1", name, bus.out_valid);
    end
    checks++;
    if (bus.c !== exp_c) begin
      failures++;
      $display("FAIL %s_c got=%h want=%h", name, bus.c, exp_c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    logic [W-1:0]   sa[4];
    logic [W-1:0]   sb[4];
    logic [2*W-1:0] se[4];
    for (int i = 0; i < 4; i++) begin
      sa[i] = W'($urandom_range(1, 65535));
      sb[i] = W'($urandom_range(1, 65535));
      se[i] = model(sa[i], sb[i]);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          logic acc;
          acc = 1'b0;
          bus.in_valid = 1'b1;
          bus.a = sa[i];
          bus.b = sb[i];
          for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
          end
          if (!acc) begin
            checks++;
            failures++;
            $display("FAIL stall_accept_timeout pair=%0d got=not_accepted want=accepted", i);
          end
        end
        bus.in_valid = 1'b0;
      end
      begin
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(negedge clk);
          seen = bus.out_valid;
        end
        checks++;
        if (!seen) begin
          failures++;
          $display("FAIL stall_first_valid got=0 want=1");
        end
        for (int h = 0; h < 5; h++) begin
          checks++;
          if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready cyc=%0d got=%b want=0", h, bus.in_ready);
          end
          checks++;
          if (bus.out_valid !== 1'b1 || bus.c !== se[0]) begin
            failures++;
            $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", h, bus.out_valid, bus.c, se[0]);
          end
          if (h < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.c !== se[i]) begin
            failures++;
            $display("FAIL stall_drain idx=%0d got=%b/%h want=1/%h", i, bus.out_valid, bus.c, se[i]);
          end
        end
        @(posedge clk);
        #1;
      end
    join
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_extra got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_flight();
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'(100 + i);
      bus.b = W'(7 + i);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flight_in_ready idx=%0d got=%b want=1", i, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flight_rst_valid got=%b want=0", bus.out_valid);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flight_ghost cyc=%0d got=%b want=0", i, bus.out_valid);
      end
    end
`ifdef MITCHELL_STATS_EN
    checks++;
    if (prod_cnt !== '0) begin
      failures++;
      $display("FAIL flight_prod_cnt got=%0d want=0", prod_cnt);
    end
`endif
    test_latency(16'd1234, 16'd4321, model(16'd1234, 16'd4321), "after_reset");
  endtask

  task automatic test_stream();
    int got;
    int sent;
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    got  = 0;
    sent = 0;
    fork
      begin
        for (int cyc = 0; cyc < 20000 && sent < NSTREAM; cyc++) begin
          if (!bus.in_valid && ($urandom % 4 != 0)) begin
            bus.in_valid = 1'b1;
            bus.a = pick_operand();
            bus.b = pick_operand();
          end
          @(negedge clk);
          if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b));
            sent++;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
          end else begin
            @(posedge clk);
            #1;
          end
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 20000 && got < NSTREAM; cyc++) begin
          bus.out_ready = ($urandom % 3 != 0);
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            logic [2*W-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL stream_unexpected idx=%0d got=%h want=none", got, bus.c);
            end else begin
              e = exp_q.pop_front();
              if (bus.c !== e) begin
                failures++;
                $display("FAIL stream_c idx=%0d got=%h want=%h", got, bus.c, e);
              end
            end
            got++;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    checks++;
    if (got != NSTREAM || sent != NSTREAM) begin
      failures++;
      $display("FAIL stream_count got=%0d/%0d want=%0d", sent, got, NSTREAM);
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_leftover got=%b want=0", bus.out_valid);
    end
`ifdef MITCHELL_STATS_EN
    checks++;
    if (prod_cnt !== CNT_W'(NSTREAM)) begin
      failures++;
      $display("FAIL stream_prod_cnt got=%0d want=%0d", prod_cnt, NSTREAM);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_latency(16'd3,     16'd3,     32'd8,          "mul_3x3");
    test_latency(16'd5,     16'd7,     32'd32,         "mul_5x7");
    test_latency(16'hFFFF,  16'hFFFF,  32'hFFFE0000,   "mul_max");
    test_latency(16'd256,   16'd128,   32'd32768,      "mul_pow2");
    test_latency(16'd0,     16'd123,   32'd0,          "zero_a");
    test_latency(16'd977,   16'd0,     32'd0,          "zero_b");
    test_stall();
    test_reset_flight();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mitchell_mul_pipe.md
Name: mitchell_mul_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational Mitchell log multiplier.
- Computes the Mitchell approximate unsigned product of two W-bit operands.
- Three-stage pipeline with valid/ready handshakes on both sides, so it can sit inside streaming datapaths.
- The result is bit-identical to the combinational Mitchell model for all operands, so the existing test-vector files remain valid when W=16.

Parameters:
- W, 16, operand width in bits (>= 4); product width is 2W.
- CNT_W, 32, width of the optional completed-product counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- c  out  2W  approximate product.
- prod_cnt  out  CNT_W  completed-product count (present only with MITCHELL_STATS_EN).

Behaviour:
- Reset (async assert, sync deassert by the user):
  - out_valid=0, c=0, all internal stage valid bits 0, all pipeline registers 0, prod_cnt=0.
  - Reset mid-operation discards every in-flight product; nothing is emitted after release.
- Arithmetic, per operand pair:
  - If a==0 or b==0: c=0.
  - Otherwise k1/k2 = index of the leading one of a/b.
  - fa = (a << (W-1-k1)) mod 2^(W-1); fb likewise. Both are W-1 fraction bits.
  - s = fa+fb, W bits.
  - If s < 2^(W-1): mant = 2^(W-1)+s, e = k1+k2.
  - Else: mant = s, e = k1+k2+1.
  - c = floor((mant << e) / 2^(W-1)). Computed exactly in 3W-1 bits, then the low W-1 bits are dropped. Never overflows 2W bits.
- Pipeline stages:
  - S1: register a and b, zero flag, k1, k2 (leading-one detectors).
  - S2: register s and e, selected mantissa, zero flag.
  - S3: barrel shift and truncation into the c output register.
- Handshake:
  - Global advance enable adv = !out_valid || out_ready.
  - in_ready = adv (combinational from out_valid and out_ready only; no path from in_valid).
  - On adv, each stage captures the previous stage; S1 captures {a, b, in_valid}.
  - A transfer occurs on in_valid && in_ready. An output transfer occurs on out_valid && out_ready.
  - When adv=0, all stages hold and c/out_valid remain stable.
  - Bubbles are not compressed.
- Latency and throughput:
  - Input transfer at cycle N gives out_valid at N+3 with no stall.
  - Throughput is 1 product/cycle while out_ready=1.
- Simultaneous events:
  - Output transfer and input acceptance in the same cycle are legal and required for full throughput.
  - in_valid is ignored while in_ready=0; the source must hold a and b stable.
- Order is preserved; no product is dropped or duplicated.

Optional Feature:
- Macro: MITCHELL_STATS_EN.
- Defined:
  - Adds the prod_cnt output.
  - prod_cnt increments by 1 on every output transfer (out_valid && out_ready).
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared only by rst_n.
- Undefined: no prod_cnt port, no counter logic; datapath and handshake identical.

Test Plan (W=16):
- a=3, b=3, out_ready=1 -> c=8 exactly 3 cycles after acceptance. Also a=5, b=7 -> c=32.
- a=65535, b=65535 -> c=0xFFFE0000. Also a=256, b=128 -> c=32768 (powers of two exact).
- a=0, b=123 and a=977, b=0 -> c=0 with normal 3-cycle latency and out_valid=1.
- Issue 4 back-to-back pairs, hold out_ready=0 for 5 cycles after first out_valid:
  - in_ready=0 during the hold, c stable.
  - Then out_ready=1 -> 4 products in order, one per cycle, no loss.
- Assert rst_n=0 with 3 products in flight, release:
  - out_valid stays 0 until a new input.
  - prod_cnt=0 (with MITCHELL_STATS_EN).
- Stream the 1000 pairs from the existing Mitchell vector files with random out_ready gaps:
  - All outputs match the expected file.
  - prod_cnt=1000 at end (with MITCHELL_STATS_EN).
